// File: rtl/odu_frame_checker_if.sv
// FIFO read-side bundle between the ODU generator's sync FIFO and the frame checker.
// r_data layout: [386]=valid, [385]=frame_start, [384]=row_start, [383:0]=data.
// master: the reader (checker) side; slave: the FIFO side.
interface odu_frame_checker_if;
    logic         fifo_empty;
    logic [386:0] fifo_data_in;
    logic         fifo_read_enable;

    modport master (
        input  fifo_empty,
        input  fifo_data_in,
        output fifo_read_enable
    );

    modport slave (
        output fifo_empty,
        output fifo_data_in,
        input  fifo_read_enable
    );
endinterface

// File: rtl/odu_frame_checker.sv
// ODU frame checker: drains the generator FIFO, hunts for frame alignment, tracks
// row/word position, checks start markers and a 32-bit incrementing payload count.
// Optional macro ODU_CHK_STATS_EN builds the saturating frame/error counters;
// without it those outputs are tied to zero and no counter flops exist.
module odu_frame_checker #(
    parameter int WORDS_PER_ROW  = 80,
    parameter int ROWS_PER_FRAME = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    odu_frame_checker_if.master   fifo,
    output logic                  frame_lock,
    output logic                  frame_done,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [CNT_WIDTH-1:0]  align_err_count,
    output logic [CNT_WIDTH-1:0]  data_err_count
);
    localparam int WW = $clog2(WORDS_PER_ROW);
    localparam int RW = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;
    localparam logic [WW-1:0] W_LAST = WW'(WORDS_PER_ROW - 1);
    localparam logic [RW-1:0] R_LAST = RW'(ROWS_PER_FRAME - 1);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t        state_q, state_d;
    logic          rd_d1_q;
    logic [WW-1:0] word_idx_q, word_idx_d;
    logic [RW-1:0] row_idx_q, row_idx_d;
    logic [31:0]   exp_cnt_q, exp_cnt_d;
    logic          frame_done_q, frame_done_d;

    logic        w_valid, w_fs, w_rs;
    logic [31:0] w_cnt;
    logic        taken, exp_rs, exp_fs, data_ok;
    logic        lock_ok, lock_bad;

    assign fifo.fifo_read_enable = enable & ~fifo.fifo_empty;

    assign w_valid = fifo.fifo_data_in[386];
    assign w_fs    = fifo.fifo_data_in[385];
    assign w_rs    = fifo.fifo_data_in[384];
    assign w_cnt   = fifo.fifo_data_in[31:0];

    // r_data follows the strobe by one cycle; invalid words are dropped outright
    assign taken   = rd_d1_q & w_valid;
    assign exp_rs  = (word_idx_q == '0);
    assign exp_fs  = exp_rs & (row_idx_q == '0);
    assign data_ok = (w_cnt == exp_cnt_q);

    // Hunt/track decision and position advance for the word taken this cycle
    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        row_idx_d    = row_idx_q;
        exp_cnt_d    = exp_cnt_q;
        frame_done_d = 1'b0;
        lock_ok      = 1'b0;
        lock_bad     = 1'b0;
        case (state_q)
            HUNT: begin
                if (taken && w_fs && w_rs) begin
                    state_d    = LOCKED;
                    word_idx_d = WW'(1);
                    row_idx_d  = '0;
                    exp_cnt_d  = w_cnt + 32'd1;
                end
            end
            LOCKED: begin
                if (taken) begin
                    if ((w_fs != exp_fs) || (w_rs != exp_rs)) begin
                        // Marker slip: drop lock, leave position/count untouched
                        lock_bad = 1'b1;
                        state_d  = HUNT;
                    end else begin
                        lock_ok   = 1'b1;
                        // On mismatch resync to the received value
                        exp_cnt_d = data_ok ? (exp_cnt_q + 32'd1) : (w_cnt + 32'd1);
                        if (word_idx_q == W_LAST) begin
                            word_idx_d = '0;
                            if (row_idx_q == R_LAST) begin
                                row_idx_d    = '0;
                                frame_done_d = 1'b1;
                            end else begin
                                row_idx_d = row_idx_q + RW'(1);
                            end
                        end else begin
                            word_idx_d = word_idx_q + WW'(1);
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // Core state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= HUNT;
            rd_d1_q      <= 1'b0;
            word_idx_q   <= '0;
            row_idx_q    <= '0;
            exp_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_d1_q      <= fifo.fifo_read_enable;
            word_idx_q   <= word_idx_d;
            row_idx_q    <= row_idx_d;
            exp_cnt_q    <= exp_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_lock = (state_q == LOCKED);
    assign frame_done = frame_done_q;

`ifdef ODU_CHK_STATS_EN
    logic [CNT_WIDTH-1:0] frame_cnt_q, align_cnt_q, data_cnt_q;
    logic                 data_err;

    assign data_err = lock_ok & ~data_ok;

    // Saturating statistics; a data error and a frame completion may coincide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
            align_cnt_q <= '0;
            data_cnt_q  <= '0;
        end else begin
            if (frame_done_d && (frame_cnt_q != '1)) frame_cnt_q <= frame_cnt_q + 1'b1;
            if (lock_bad && (align_cnt_q != '1))     align_cnt_q <= align_cnt_q + 1'b1;
            if (data_err && (data_cnt_q != '1))      data_cnt_q  <= data_cnt_q + 1'b1;
        end
    end

    assign frame_count     = frame_cnt_q;
    assign align_err_count = align_cnt_q;
    assign data_err_count  = data_cnt_q;
`else
    assign frame_count     = '0;
    assign align_err_count = '0;
    assign data_err_count  = '0;
`endif

endmodule

// File: tb/tb_odu_frame_checker.sv
// Bench for odu_frame_checker: scenario table plus per-cycle comparison against a
// word-stream reference model that tracks frame position as a single integer.
module tb_odu_frame_checker;
    localparam int W  = 80;
    localparam int R  = 4;
    localparam int FW = W * R;
    localparam int CW = 16;
`ifdef ODU_CHK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          frame_lock, frame_done;
    logic [CW-1:0] frame_count, align_err_count, data_err_count;

    odu_frame_checker_if fifo_if();

    odu_frame_checker #(.WORDS_PER_ROW(W), .ROWS_PER_FRAME(R), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .fifo            (fifo_if),
        .frame_lock      (frame_lock),
        .frame_done      (frame_done),
        .frame_count     (frame_count),
        .align_err_count (align_err_count),
        .data_err_count  (data_err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [386:0] src [0:2047];
    int n, rp;
    bit tb_rd_d1;

    // reference model state
    bit          m_lock, m_done;
    int          m_pos, m_fc, m_ac, m_dc, m_taken;
    logic [31:0] m_exp;

    typedef struct {
        int start; int len; int kind; int rst_at;
        int exp_fc; int exp_ac; int exp_dc; int exp_lock; int chk_final;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
    endfunction

    task automatic model_reset();
        m_lock = 0; m_done = 0; m_pos = 0; m_exp = '0;
        m_fc = 0; m_ac = 0; m_dc = 0;
    endtask

    task automatic model_take(input logic [386:0] w);
        logic fs, rs;
        logic [31:0] d;
        if (!w[386]) return;
        m_taken++;
        fs = w[385]; rs = w[384]; d = w[31:0];
        if (!m_lock) begin
            if (fs && rs) begin
                m_lock = 1; m_pos = 1; m_exp = d + 32'd1;
            end
        end else if (fs != (m_pos == 0) || rs != (m_pos % W == 0)) begin
            m_ac = sat(m_ac); m_lock = 0;
        end else begin
            if (d != m_exp) m_dc = sat(m_dc);
            m_exp = d + 32'd1;
            if (m_pos == FW - 1) begin
                m_done = 1; m_fc = sat(m_fc);
            end
            m_pos = (m_pos + 1) % FW;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".frame_lock"}, 64'(frame_lock), 64'(m_lock));
        chk({tag, ".frame_done"}, 64'(frame_done), 64'(m_done));
        chk({tag, ".frame_count"}, 64'(frame_count), STATS ? 64'(m_fc) : 64'd0);
        chk({tag, ".align_err_count"}, 64'(align_err_count), STATS ? 64'(m_ac) : 64'd0);
        chk({tag, ".data_err_count"}, 64'(data_err_count), STATS ? 64'(m_dc) : 64'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".frame_lock"}, 64'(frame_lock), 64'd0);
        chk({tag, ".frame_done"}, 64'(frame_done), 64'd0);
        chk({tag, ".frame_count"}, 64'(frame_count), 64'd0);
        chk({tag, ".align_err_count"}, 64'(align_err_count), 64'd0);
        chk({tag, ".data_err_count"}, 64'(data_err_count), 64'd0);
    endtask

    task automatic push_invalid();
        logic [386:0] w;
        w = '0;
        w[385] = 1'b1; w[384] = 1'b1;  // markers set but valid=0: must be ignored
        w[31:0] = $urandom;
        src[n] = w; n++;
    endtask

    task automatic build(input vec_t v);
        logic [386:0] w;
        int p, r;
        logic fs, rs;
        logic [31:0] pay;
        n = 0; rp = 0;
        for (int g = v.start; g < v.start + v.len; g++) begin
            if (v.kind == 3 && (g == 30 || g == 200)) push_invalid();
            if (v.kind == 4 && $urandom_range(0, 15) == 0) push_invalid();
            p = g % FW;
            fs = (p == 0); rs = (p % W == 0); pay = 32'(g);
            if (v.kind == 1 && g == 80) rs = 1'b0;
            if (v.kind == 2 && g >= 50) pay = 32'(g + 2);
            if (v.kind == 4) begin
                r = $urandom_range(0, 63);
                if (r == 0) rs = ~rs;
                if (r == 1) fs = ~fs;
                if (r == 2) pay = pay + 32'd7;
            end
            w = '0;
            w[386] = 1'b1; w[385] = fs; w[384] = rs;
            w[63:32] = $urandom;
            w[31:0] = pay;
            src[n] = w; n++;
        end
    endtask

    task automatic do_reset();
        logic [386:0] junk;
        junk = '0;
        junk[386] = 1'b1; junk[385] = 1'b1; junk[384] = 1'b1;  // un-strobed word must not lock
        rst = 1'b0; enable = 1'b0;
        fifo_if.fifo_empty = 1'b1;
        fifo_if.fifo_data_in = junk;
        #1;
        check_zero("reset");
        model_reset(); m_taken = 0; tb_rd_d1 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic step(input int kind, input int cyc);
        logic en, emp, rd_now, tk;
        logic [386:0] w;
        en = 1'b1; emp = 1'b0;
        if (kind == 3) begin
            if (cyc >= 100 && cyc < 105) emp = 1'b1;
            if (cyc >= 150 && cyc < 153) en = 1'b0;
        end else if (kind == 4) begin
            emp = ($urandom_range(0, 3) == 0);
            en  = ($urandom_range(0, 7) != 0);
        end
        if (rp >= n) emp = 1'b1;
        enable = en;
        fifo_if.fifo_empty = emp;
        rd_now = en & ~emp;
        #1 chk("fifo_read_enable", 64'(fifo_if.fifo_read_enable), 64'(rd_now));
        tk = tb_rd_d1;
        w = fifo_if.fifo_data_in;
        @(posedge clk);
        #1;
        m_done = 0;
        if (tk) model_take(w);
        if (rd_now) begin
            fifo_if.fifo_data_in = src[rp];
            rp++;
        end
        tb_rd_d1 = rd_now;
        check_outputs("run");
    endtask

    initial begin
        vec_t tbl [7];
        int cyc;
        bit did_rst;
        tbl[0] = '{0,   640, 0, -1,  2, 0, 0, 1, 1};  // two clean frames
        tbl[1] = '{100, 860, 0, -1,  2, 0, 0, 1, 1};  // join mid-frame, lock at word 320
        tbl[2] = '{0,   960, 1, -1,  2, 1, 0, 1, 1};  // row_start lost at row 1 word 0
        tbl[3] = '{0,   320, 2, -1,  1, 0, 1, 1, 1};  // payload skip at word 50
        tbl[4] = '{0,   320, 3, -1,  1, 0, 0, 1, 1};  // empty/enable gaps + invalid words
        tbl[5] = '{0,   640, 0, 150, 1, 0, 0, 1, 1};  // reset mid-frame
        tbl[6] = '{0,   960, 4, -1,  0, 0, 0, 0, 0};  // random gaps and corruption

        fifo_if.fifo_empty = 1'b1;
        fifo_if.fifo_data_in = '0;
        tb_rd_d1 = 0;

        for (int i = 0; i < 7; i++) begin
            build(tbl[i]);
            do_reset();
            cyc = 0; did_rst = 0;
            while ((rp < n || tb_rd_d1) && cyc < 8000) begin
                step(tbl[i].kind, cyc);
                cyc++;
                if (tbl[i].rst_at >= 0 && !did_rst && m_taken == tbl[i].rst_at) begin
                    did_rst = 1;
                    rst = 1'b0;
                    #1 check_zero("mid_reset");
                    model_reset(); tb_rd_d1 = 0;
                    #2 rst = 1'b1;
                end
            end
            if (cyc >= 8000) begin
                checks++; failures++;
                $display("FAIL drain_timeout: scenario %0d consumed %0d of %0d words", i, rp, n);
            end
            if (tbl[i].chk_final != 0) begin
                chk($sformatf("s%0d.final_lock", i), 64'(frame_lock), 64'(tbl[i].exp_lock));
                chk($sformatf("s%0d.final_frame_count", i), 64'(frame_count),
                    STATS ? 64'(tbl[i].exp_fc) : 64'd0);
                chk($sformatf("s%0d.final_align_err", i), 64'(align_err_count),
                    STATS ? 64'(tbl[i].exp_ac) : 64'd0);
                chk($sformatf("s%0d.final_data_err", i), 64'(data_err_count),
                    STATS ? 64'(tbl[i].exp_dc) : 64'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
